fifo_wr_ctrl: RTL and testbench
===============================

// Module: fifo_wr_ctrl
// PURPOSE
//   Write-side pointer/flag controller of the async FIFO, in the wclk domain.
//   Converts write requests into waddr/wrclken for the dual-port RegFile.
//   Exports the Gray write pointer for synchronisation into the read domain.
//   Derives full, almost-full, fill level and sticky overflow from the read
//   pointer already synchronised into wclk.
// PARAMETERS
//   PTR_SIZE   4  pointer width incl. wrap bit; depth DEPTH = 2**(PTR_SIZE-1)
//   AFULL_LVL  6  walmost_full threshold, legal range 1..DEPTH
// PORTS
//   wclk          in   1           write clock
//   wrst_n        in   1           async active-low reset
//   winc          in   1           write request, qualified internally by !wfull
//   wq2_rptr      in   PTR_SIZE    Gray read pointer, 2-FF synchronised into wclk
//   wovf_clr      in   1           clears wovf
//   wrclken       out  1           RegFile write enable = winc & !wfull (comb)
//   waddr         out  PTR_SIZE-1  RegFile write address = wbin[PTR_SIZE-2:0]
//   wptr          out  PTR_SIZE    registered Gray write pointer (to read-side sync)
//   wfull         out  1           FIFO full, registered
//   walmost_full  out  1           level >= AFULL_LVL, registered
//   wlevel        out  PTR_SIZE    fill count 0..DEPTH, registered
//   wovf          out  1           sticky: write attempted while full
// BEHAVIOUR
// - Reset (wrst_n=0, async): wbin, wptr, wfull, walmost_full, wlevel and wovf
//   are all 0. waddr=0. wrclken follows winc.
// - Pointers: wbin_nxt = wbin + wrclken, mod 2**PTR_SIZE.
//   wgray_nxt = (wbin_nxt>>1) ^ wbin_nxt. Both are registered on posedge wclk.
// - Writes: data is written by the RegFile on the same edge that advances
//   wbin. waddr is the current wbin, so zero latency from winc to write.
// - Full: wfull <= (wgray_nxt == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}).
//   Full asserts on the edge that performs the DEPTH-th outstanding write.
//   Full deasserts one wclk after wq2_rptr moves. This is pessimistic because
//   of the sync delay. It never under-reports.
// - Level: rbin = gray2bin(wq2_rptr) (comb XOR prefix).
//   wlevel <= wbin_nxt - rbin, mod 2**PTR_SIZE, PTR_SIZE bits wide, never
//   exceeds DEPTH. walmost_full <= (wbin_nxt - rbin) >= AFULL_LVL.
// - Overflow: winc & wfull blocks the write. wrclken=0 and the pointers hold.
//   wovf <= 1 on that edge. wovf_clr clears it next edge. If a set and a clear
//   occur in the same cycle, the set wins.
// - Wrap-around: wbin rolls over 2**PTR_SIZE-1 -> 0. waddr rolls DEPTH-1 -> 0.
//   The Gray wrap changes exactly one bit. No false full or level glitch.
// - Simultaneous winc and read-pointer advance: both are counted in the same
//   cycle. wfull/wlevel reflect both on the next edge.
// - Reset mid-operation: all state clears immediately. The read side must
//   also be reset. Stored RegFile contents are not relied upon.
// - wptr is driven directly from a flop. There is no combinational path to the
//   read domain.
// TESTING (PTR_SIZE=4, AFULL_LVL=6, wq2_rptr=0 unless stated)
// 1 Reset: assert wrst_n=0 mid-cycle -> waddr=0, wptr=0000, wfull=0, wlevel=0,
//   wovf=0 immediately.
// 2 Fill: winc=1 for 8 cycles -> waddr 0..7, wptr 1,3,2,6,7,5,4,C.
//   walmost_full=1 after write 6. After write 8: wfull=1, wlevel=8.
// 3 Overflow: 9th winc while full -> wrclken=0, wptr stays 1100, wovf=1.
//   Pulse wovf_clr -> wovf=0. Simultaneous winc and wovf_clr while full
//   -> wovf stays 1.
// 4 Release: from full, wq2_rptr=0001 -> next edge wfull=0, wlevel=7,
//   walmost_full=1. Then wq2_rptr=0011 -> wlevel=6.
// 5 Wrap: 20 writes, read pointer trailing by 2 (Gray) -> wbin wraps 15->0,
//   waddr 7->0, wfull never 1, wlevel=2 steady.
// 6 Async reset at level 5 -> all outputs 0. First write after reset goes to
//   waddr=0, wptr=0001.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Purpose : write-side pointer and flag controller of an async FIFO, in the wclk domain.
// Latency : wrclken/waddr are combinational from winc. Pointer, flags and level are registered (1 wclk).
// Backpr. : writes are blocked while wfull is set. A blocked write sets the sticky wovf flag.
//
// Ports
//   wclk_i           write clock
//   wrst_n_i         async active-low reset
//   winc_i           write request. It is qualified internally by !wfull.
//   wq2_rptr_i       Gray read pointer, already 2-FF synchronised into wclk
//   wovf_clr_i       clears the sticky overflow flag on the next edge
//   wrclken_o        RegFile write enable = winc & !wfull
//   waddr_o          RegFile write address (low bits of the binary write pointer)
//   wptr_o           registered Gray write pointer, sent to the read-side synchroniser
//   wfull_o          FIFO full
//   walmost_full_o   fill level >= AFULL_LVL
//   wlevel_o         fill count 0..DEPTH
//   wovf_o           sticky flag: a write was attempted while full
//
// PTR_SIZE includes the wrap bit, so DEPTH = 2**(PTR_SIZE-1). PTR_SIZE must be >= 3.
// AFULL_LVL must lie in 1..DEPTH.

module fifo_wr_ctrl #(
    parameter int PTR_SIZE  = 4,
    parameter int AFULL_LVL = 6
) (
    input  logic                wclk_i,
    input  logic                wrst_n_i,
    input  logic                winc_i,
    input  logic [PTR_SIZE-1:0] wq2_rptr_i,
    input  logic                wovf_clr_i,
    output logic                wrclken_o,
    output logic [PTR_SIZE-2:0] waddr_o,
    output logic [PTR_SIZE-1:0] wptr_o,
    output logic                wfull_o,
    output logic                walmost_full_o,
    output logic [PTR_SIZE-1:0] wlevel_o,
    output logic                wovf_o
);

    localparam logic [PTR_SIZE-1:0] AFULL_THR = PTR_SIZE'(AFULL_LVL);

    // Gray to binary conversion: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_SIZE-1:0] gray2bin(input logic [PTR_SIZE-1:0] g);
        logic [PTR_SIZE-1:0] b;
        b[PTR_SIZE-1] = g[PTR_SIZE-1];
        for (int i = PTR_SIZE - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // State registers and their next-state values
    logic [PTR_SIZE-1:0] wbin_q,   wbin_d;
    logic [PTR_SIZE-1:0] wgray_q,  wgray_d;
    logic                wfull_q,  wfull_d;
    logic                wafull_q, wafull_d;
    logic [PTR_SIZE-1:0] wlevel_q, wlevel_d;
    logic                wovf_q,   wovf_d;

    // Combinational helpers
    logic                wr_en;
    logic                wr_blocked;
    logic [PTR_SIZE-1:0] rbin;
    logic [PTR_SIZE-1:0] rgray_full;

    // The write is qualified by the registered full flag. This keeps the enable
    // free of any path through the read pointer or the level arithmetic.
    assign wr_en      = winc_i & ~wfull_q;
    assign wr_blocked = winc_i &  wfull_q;

    assign rbin = gray2bin(wq2_rptr_i);

    // In Gray code, "one lap ahead" means the top two bits are inverted and the
    // rest are equal. This detects full without converting the write pointer.
    assign rgray_full = {~wq2_rptr_i[PTR_SIZE-1:PTR_SIZE-2], wq2_rptr_i[PTR_SIZE-3:0]};

    always_comb begin
        wbin_d   = wbin_q + {{(PTR_SIZE-1){1'b0}}, wr_en};
        wgray_d  = (wbin_d >> 1) ^ wbin_d;
        wfull_d  = (wgray_d == rgray_full);
        // The modulo subtraction is exact as long as the read side never
        // overtakes the write side. The synchronised read pointer can only lag,
        // so the level over-reports. It never under-reports.
        wlevel_d = wbin_d - rbin;
        wafull_d = (wlevel_d >= AFULL_THR);
        // A blocked write takes priority over a clear. An overflow in the same
        // cycle as a clear must not be lost.
        if (wr_blocked) begin
            wovf_d = 1'b1;
        end else if (wovf_clr_i) begin
            wovf_d = 1'b0;
        end else begin
            wovf_d = wovf_q;
        end
    end

    always_ff @(posedge wclk_i or negedge wrst_n_i) begin
        if (!wrst_n_i) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wlevel_q <= '0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wlevel_q <= wlevel_d;
            wovf_q   <= wovf_d;
        end
    end

    assign wrclken_o      = wr_en;
    assign waddr_o        = wbin_q[PTR_SIZE-2:0];
    // wptr comes straight from a flop, so no combinational glitch reaches the
    // read-domain synchroniser.
    assign wptr_o         = wgray_q;
    assign wfull_o        = wfull_q;
    assign walmost_full_o = wafull_q;
    assign wlevel_o       = wlevel_q;
    assign wovf_o         = wovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl with PTR_SIZE=4, AFULL_LVL=6 (depth 8).
// Uses directed scenarios plus a random run, checked against a count-based model.

module tb_fifo_wr_ctrl;

    localparam int PS    = 4;
    localparam int DEPTH = 8;
    localparam int AFL   = 6;

    logic          wclk = 1'b0;
    logic          wrst_n;
    logic          winc;
    logic [PS-1:0] wq2_rptr;
    logic          wovf_clr;
    logic          wrclken;
    logic [PS-2:0] waddr;
    logic [PS-1:0] wptr;
    logic          wfull;
    logic          walmost_full;
    logic [PS-1:0] wlevel;
    logic          wovf;

    fifo_wr_ctrl #(.PTR_SIZE(PS), .AFULL_LVL(AFL)) dut (
        .wclk_i         (wclk),
        .wrst_n_i       (wrst_n),
        .winc_i         (winc),
        .wq2_rptr_i     (wq2_rptr),
        .wovf_clr_i     (wovf_clr),
        .wrclken_o      (wrclken),
        .waddr_o        (waddr),
        .wptr_o         (wptr),
        .wfull_o        (wfull),
        .walmost_full_o (walmost_full),
        .wlevel_o       (wlevel),
        .wovf_o         (wovf)
    );

    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model. It uses plain write and read counts; the pointers are derived from them.
    int   m_wcnt;   // total accepted writes
    int   m_rcnt;   // total reads seen by the write side
    logic m_full;
    logic m_afull;
    int   m_level;
    logic m_ovf;
    logic m_winc;
    logic m_clr;

    function automatic logic [3:0] to_gray(input int n);
        logic [3:0] b;
        b = 4'(n % 16);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [10:0] exp_regs();
        return {to_gray(m_wcnt), m_full, m_afull, 4'(m_level), m_ovf};
    endfunction

    function automatic logic [10:0] act_regs();
        return {wptr, wfull, walmost_full, wlevel, wovf};
    endfunction

    task automatic model_reset();
        m_wcnt = 0; m_rcnt = 0; m_full = 0; m_afull = 0; m_level = 0; m_ovf = 0;
    endtask

    // Called just after a posedge (+1). Drives the inputs. A read is only
    // advanced when data is outstanding. Waits until the comb outputs settle.
    task automatic drive(input logic inc, input logic clr, input logic rd);
        m_winc   = inc;
        m_clr    = clr;
        if (rd && m_rcnt < m_wcnt) m_rcnt++;
        winc     = inc;
        wovf_clr = clr;
        wq2_rptr = to_gray(m_rcnt);
        #2;
    endtask

    // Advances the model by one edge, then waits to 1 time unit after that edge.
    task automatic tick();
        logic acc;
        acc = m_winc && !m_full;
        if (m_winc && m_full) m_ovf = 1'b1;
        else if (m_clr)       m_ovf = 1'b0;
        if (acc) m_wcnt++;
        m_level = m_wcnt - m_rcnt;
        m_full  = (m_level == DEPTH);
        m_afull = (m_level >= AFL);
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        wrst_n = 1'b0; winc = 1'b0; wovf_clr = 1'b0; wq2_rptr = '0;
        model_reset();
        repeat (2) @(posedge wclk);
        #1;
        n_checks++;
        if (act_regs() !== 11'd0 || waddr !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: regs=%b waddr=%0d, required all zero", act_regs(), waddr);
        end
        winc = 1'b1;
        #1;
        n_checks++;
        if (wrclken !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wrclken_follows: wrclken=%b required 1", wrclken);
        end
        winc = 1'b0;
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
    endtask

    task automatic test_fill();
        logic [3:0] tab [8];
        tab = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            n_checks++;
            if (wrclken !== 1'b1 || waddr !== 3'(i)) begin
                n_fail++;
                $display("FAIL fill_comb[%0d]: wrclken=%b waddr=%0d, required 1/%0d", i, wrclken, waddr, i);
            end
            tick();
            n_checks++;
            if (wptr !== tab[i] || act_regs() !== exp_regs()) begin
                n_fail++;
                $display("FAIL fill_regs[%0d]: wptr=%h regs=%b, required wptr=%h regs=%b",
                         i, wptr, act_regs(), tab[i], exp_regs());
            end
            n_checks++;
            if (walmost_full !== (i >= 5)) begin
                n_fail++;
                $display("FAIL fill_afull[%0d]: got %b required %b", i, walmost_full, (i >= 5));
            end
        end
        n_checks++;
        if (wfull !== 1'b1 || wlevel !== 4'd8) begin
            n_fail++;
            $display("FAIL fill_full: wfull=%b wlevel=%0d, required 1/8", wfull, wlevel);
        end
    endtask

    task automatic test_overflow();
        drive(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (wrclken !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_block: wrclken=%b required 0", wrclken);
        end
        tick();
        n_checks++;
        if (wptr !== 4'hC || wovf !== 1'b1 || act_regs() !== exp_regs()) begin
            n_fail++;
            $display("FAIL ovf_set: wptr=%h wovf=%b, required C/1", wptr, wovf);
        end
        drive(1'b0, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (wovf !== 1'b0 || act_regs() !== exp_regs()) begin
            n_fail++;
            $display("FAIL ovf_clear: wovf=%b required 0", wovf);
        end
        drive(1'b1, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (wovf !== 1'b1 || act_regs() !== exp_regs()) begin
            n_fail++;
            $display("FAIL ovf_set_wins: wovf=%b required 1", wovf);
        end
        drive(1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_release();
        drive(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (wq2_rptr !== 4'b0001 || wfull !== 1'b1) begin
            n_fail++;
            $display("FAIL release_pre: rptr=%b wfull=%b, required 0001/1", wq2_rptr, wfull);
        end
        tick();
        n_checks++;
        if (wfull !== 1'b0 || wlevel !== 4'd7 || walmost_full !== 1'b1 || act_regs() !== exp_regs()) begin
            n_fail++;
            $display("FAIL release_1: wfull=%b wlevel=%0d afull=%b, required 0/7/1", wfull, wlevel, walmost_full);
        end
        drive(1'b0, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (wq2_rptr !== 4'b0011 || wlevel !== 4'd6 || act_regs() !== exp_regs()) begin
            n_fail++;
            $display("FAIL release_2: wlevel=%0d required 6", wlevel);
        end
    endtask

    task automatic test_wrap();
        bit saw_wrap = 0;
        // Drain until the read side trails by 2.
        while (m_wcnt - m_rcnt > 2) begin
            drive(1'b0, 1'b0, 1'b1);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            logic [2:0] prev_addr;
            prev_addr = waddr;
            drive(1'b1, 1'b0, 1'b1);
            tick();
            if (prev_addr == 3'd7 && waddr == 3'd0) saw_wrap = 1;
            n_checks++;
            if (wfull !== 1'b0 || wlevel !== 4'd2 || act_regs() !== exp_regs()) begin
                n_fail++;
                $display("FAIL wrap[%0d]: regs=%b, required %b (level 2, not full)", i, act_regs(), exp_regs());
            end
        end
        n_checks++;
        if (!saw_wrap || m_wcnt < 16) begin
            n_fail++;
            $display("FAIL wrap_rollover: saw_wrap=%0d writes=%0d, required 1/>=16", saw_wrap, m_wcnt);
        end
    endtask

    task automatic test_reset_mid();
        while (m_wcnt - m_rcnt < 5) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        n_checks++;
        if (wlevel !== 4'd5) begin
            n_fail++;
            $display("FAIL midrst_pre: wlevel=%0d required 5", wlevel);
        end
        winc = 1'b0;
        #2;
        wrst_n = 1'b0;
        #1;
        model_reset();
        wq2_rptr = '0;
        n_checks++;
        if (act_regs() !== 11'd0 || waddr !== 3'd0) begin
            n_fail++;
            $display("FAIL midrst_clear: regs=%b waddr=%0d, required all zero", act_regs(), waddr);
        end
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
        drive(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (waddr !== 3'd0 || wrclken !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_first_addr: waddr=%0d wrclken=%b, required 0/1", waddr, wrclken);
        end
        tick();
        n_checks++;
        if (wptr !== 4'b0001 || act_regs() !== exp_regs()) begin
            n_fail++;
            $display("FAIL midrst_first_ptr: wptr=%b required 0001", wptr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic inc, clr, rd;
            inc = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 7) == 0);
            rd  = ($urandom_range(0, 2) == 0);
            drive(inc, clr, rd);
            n_checks++;
            if (wrclken !== (inc && !m_full) || waddr !== 3'(m_wcnt % DEPTH)) begin
                n_fail++;
                $display("FAIL rand_comb[%0d]: wrclken=%b waddr=%0d, required %b/%0d",
                         i, wrclken, waddr, (inc && !m_full), m_wcnt % DEPTH);
            end
            tick();
            n_checks++;
            if (act_regs() !== exp_regs()) begin
                n_fail++;
                $display("FAIL rand_regs[%0d]: regs=%b required %b", i, act_regs(), exp_regs());
            end
        end
    endtask

    initial begin
        m_winc = 0;
        m_clr  = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
